// File: rtl/rocketcpu_wb_interconnect_pkg.sv
// Shared types and the default SoC memory map for the
// rocketcpu Wishbone 1-master/N-slave interconnect.
package rocketcpu_wb_interconnect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2,
        ST_DONE = 2'd3
    } wb_state_e;

    localparam int unsigned MAP_NSLAVES = 6;

    localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK   = 32'hFFFF_8000;
    localparam logic [31:0] FLASH_BASE = 32'h0010_0000;
    localparam logic [31:0] FLASH_MASK = 32'hFFF0_0000;
    localparam logic [31:0] GPIO_BASE  = 32'h0200_0000;
    localparam logic [31:0] GPIO_MASK  = 32'hFFFF_FFFF;
    localparam logic [31:0] UART_BASE  = 32'h0400_0000;
    localparam logic [31:0] UART_MASK  = 32'hFFFF_FFFF;
    localparam logic [31:0] TIMER_BASE = 32'h0800_0000;
    localparam logic [31:0] TIMER_MASK = 32'hFFFF_FFFF;
    localparam logic [31:0] AUDIO_BASE = 32'h1000_0000;
    localparam logic [31:0] AUDIO_MASK = 32'hF000_0000;

    // Slave k lives at [k*32 +: 32]
    localparam logic [MAP_NSLAVES*32-1:0] MAP_BASE = {
        AUDIO_BASE, TIMER_BASE, UART_BASE,
        GPIO_BASE, FLASH_BASE, RAM_BASE
    };
    localparam logic [MAP_NSLAVES*32-1:0] MAP_MASK = {
        AUDIO_MASK, TIMER_MASK, UART_MASK,
        GPIO_MASK, FLASH_MASK, RAM_MASK
    };

    // gpio (s2) and timer (s4) never drive an ack
    localparam logic [MAP_NSLAVES-1:0] MAP_AUTOACK = 6'b01_0100;

endpackage

// File: rtl/rocketcpu_wb_interconnect_addr_decode.sv
// Combinational address window match with lowest-index
// priority; overlapping windows resolve to the lowest slave.
module rocketcpu_wb_interconnect_addr_decode #(
    parameter int unsigned               NSLAVES    = 6,
    parameter int unsigned               AW         = 32,
    parameter logic [NSLAVES*AW-1:0]     SLAVE_BASE = '0,
    parameter logic [NSLAVES*AW-1:0]     SLAVE_MASK = '0
) (
    input  logic [AW-1:0]      adr_i,
    output logic [NSLAVES-1:0] hit_o,
    output logic               hit_any_o
);

    logic [NSLAVES-1:0] raw;

    // Raw window hits for every slave
    always_comb begin
        raw = '0;
        for (int k = 0; k < NSLAVES; k++) begin
            raw[k] = (adr_i & SLAVE_MASK[k*AW +: AW])
                     == SLAVE_BASE[k*AW +: AW];
        end
    end

    // Keep only the lowest matching slave
    always_comb begin
        logic found;
        found = 1'b0;
        hit_o = '0;
        for (int k = 0; k < NSLAVES; k++) begin
            if (raw[k] && !found) begin
                hit_o[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign hit_any_o = |raw;

endmodule

// File: rtl/rocketcpu_wb_interconnect.sv
// Wishbone-classic 1-master/N-slave interconnect: registered
// decode, auto-ack, bus watchdog and sticky error capture.
module rocketcpu_wb_interconnect
    import rocketcpu_wb_interconnect_pkg::*;
#(
    parameter int unsigned           NSLAVES    = 6,
    parameter int unsigned           AW         = 32,
    parameter int unsigned           DW         = 32,
    parameter logic [NSLAVES*AW-1:0] SLAVE_BASE = '0,
    parameter logic [NSLAVES*AW-1:0] SLAVE_MASK = '0,
    parameter logic [NSLAVES-1:0]    AUTOACK    = '0,
    parameter int unsigned           TIMEOUT    = 255,
    parameter logic [DW-1:0]         ERR_RDT    = 32'hDEAD_BEEF
) (
    input  logic                  i_wb_clk,
    input  logic                  i_wb_rst_n,
    input  logic [AW-1:0]         i_wb_adr,
    input  logic [DW-1:0]         i_wb_dat,
    input  logic [DW/8-1:0]       i_wb_sel,
    input  logic                  i_wb_we,
    input  logic                  i_wb_cyc,
    output logic [DW-1:0]         o_wb_rdt,
    output logic                  o_wb_ack,
    output logic [AW-1:0]         o_s_adr,
    output logic [DW-1:0]         o_s_dat,
    output logic [DW/8-1:0]       o_s_sel,
    output logic                  o_s_we,
    output logic [NSLAVES-1:0]    o_s_cyc,
    input  logic [NSLAVES*DW-1:0] i_s_rdt,
    input  logic [NSLAVES-1:0]    i_s_ack,
    input  logic                  i_err_clr,
    output logic                  o_err,
    output logic                  o_err_to,
    output logic [AW-1:0]         o_err_adr
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [1:0]         rst_sync_q;
    logic               rst_int_n;

    wb_state_e          state_q, state_d;
    logic [NSLAVES-1:0] sel_q, sel_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               err_to_q, err_to_d;
    logic [AW-1:0]      err_adr_q, err_adr_d;

    logic [NSLAVES-1:0] dec_hit;
    logic               dec_any;
    logic               first_busy;
    logic               timeout_hit;
    logic [NSLAVES-1:0] ack_vec;
    logic               slv_ack;
    logic [DW-1:0]      slv_rdt;
    logic               err_set;
    logic               err_to_new;

    assign o_s_adr = i_wb_adr;
    assign o_s_dat = i_wb_dat;
    assign o_s_sel = i_wb_sel;
    assign o_s_we  = i_wb_we;

    rocketcpu_wb_interconnect_addr_decode #(
        .NSLAVES    (NSLAVES),
        .AW         (AW),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .adr_i     (i_wb_adr),
        .hit_o     (dec_hit),
        .hit_any_o (dec_any)
    );

    // Reset asserts at once, releases two clocks later
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    assign first_busy  = (cnt_q == '0);
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    // Ack-less slaves answer on the first BUSY cycle
    assign ack_vec = (i_s_ack & ~AUTOACK)
                   | (AUTOACK & {NSLAVES{first_busy}});
    assign slv_ack = |(ack_vec & sel_q);

    // Read data of the selected slave (sel_q is one-hot)
    always_comb begin
        slv_rdt = '0;
        for (int k = 0; k < NSLAVES; k++) begin
            if (sel_q[k]) begin
                slv_rdt = slv_rdt | i_s_rdt[k*DW +: DW];
            end
        end
    end

    // Transaction FSM: next state, slave cycle, master ack/rdt
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        o_s_cyc    = '0;
        o_wb_ack   = 1'b0;
        o_wb_rdt   = '0;
        err_set    = 1'b0;
        err_to_new = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_wb_cyc) begin
                    sel_d = dec_hit;
                    cnt_d = '0;
                    if (dec_any) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_ERR;
                        err_set = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                o_s_cyc = sel_q & {NSLAVES{i_wb_cyc}};
                cnt_d   = cnt_q + CW'(1);
                if (!i_wb_cyc) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (slv_ack) begin
                    o_wb_ack = 1'b1;
                    o_wb_rdt = slv_rdt;
                    state_d  = ST_DONE;
                    cnt_d    = '0;
                end else if (timeout_hit) begin
                    state_d    = ST_ERR;
                    cnt_d      = '0;
                    err_set    = 1'b1;
                    err_to_new = 1'b1;
                end
            end
            ST_ERR: begin
                o_wb_ack = 1'b1;
                o_wb_rdt = ERR_RDT;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky error: first error after a clear wins, error beats clear
    always_comb begin
        err_d     = err_q;
        err_to_d  = err_to_q;
        err_adr_d = err_adr_q;
        if (err_set && (!err_q || i_err_clr)) begin
            err_d     = 1'b1;
            err_to_d  = err_to_new;
            err_adr_d = i_wb_adr;
        end else if (i_err_clr) begin
            err_d     = 1'b0;
            err_to_d  = 1'b0;
            err_adr_d = '0;
        end
    end

    // State, selection, watchdog and error registers
    always_ff @(posedge i_wb_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_to_q  <= 1'b0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            err_to_q  <= err_to_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign o_err     = err_q;
    assign o_err_to  = err_to_q;
    assign o_err_adr = err_adr_q;

endmodule

// File: tb/tb_rocketcpu_wb_interconnect.sv
// Randomised self-checking bench for the Wishbone interconnect
// against a transaction-level reference model.
module tb_rocketcpu_wb_interconnect;
    import rocketcpu_wb_interconnect_pkg::*;

    localparam int N  = 6;
    localparam int TO = 8;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    localparam logic [31:0] TB_BASE [N] = '{
        32'h0000_0000, 32'h0010_0000, 32'h0200_0000,
        32'h0400_0000, 32'h0800_0000, 32'h1000_0000
    };
    localparam logic [31:0] TB_MASK [N] = '{
        32'hFFFF_8000, 32'hFFF0_0000, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF000_0000
    };
    localparam bit TB_AUTO [N] = '{0, 0, 1, 0, 1, 0};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   wb_adr = '0;
    logic [31:0]   wb_dat = '0;
    logic [3:0]    wb_sel = '0;
    logic          wb_we = 1'b0;
    logic          wb_cyc = 1'b0;
    logic [31:0]   wb_rdt;
    logic          wb_ack;
    logic [31:0]   s_adr;
    logic [31:0]   s_dat;
    logic [3:0]    s_sel;
    logic          s_we;
    logic [N-1:0]  s_cyc;
    logic [N*32-1:0] s_rdt = '0;
    logic [N-1:0]  s_ack = '0;
    logic          err_clr = 1'b0;
    logic          err;
    logic          err_to;
    logic [31:0]   err_adr;

    int errors = 0;
    int checks = 0;

    logic        m_err = 1'b0;
    logic        m_to = 1'b0;
    logic [31:0] m_adr = '0;

    always #5 clk = ~clk;

    rocketcpu_wb_interconnect #(
        .NSLAVES    (N),
        .AW         (32),
        .DW         (32),
        .SLAVE_BASE (MAP_BASE),
        .SLAVE_MASK (MAP_MASK),
        .AUTOACK    (MAP_AUTOACK),
        .TIMEOUT    (TO),
        .ERR_RDT    (DEAD)
    ) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_wb_adr   (wb_adr),
        .i_wb_dat   (wb_dat),
        .i_wb_sel   (wb_sel),
        .i_wb_we    (wb_we),
        .i_wb_cyc   (wb_cyc),
        .o_wb_rdt   (wb_rdt),
        .o_wb_ack   (wb_ack),
        .o_s_adr    (s_adr),
        .o_s_dat    (s_dat),
        .o_s_sel    (s_sel),
        .o_s_we     (s_we),
        .o_s_cyc    (s_cyc),
        .i_s_rdt    (s_rdt),
        .i_s_ack    (s_ack),
        .i_err_clr  (err_clr),
        .o_err      (err),
        .o_err_to   (err_to),
        .o_err_adr  (err_adr)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_target(input logic [31:0] a);
        for (int k = 0; k < N; k++) begin
            if ((a & TB_MASK[k]) == TB_BASE[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] gen_adr(input int k);
        logic [31:0] r;
        r = $urandom;
        case (k)
            0: return r & 32'h0000_7FFC;
            1: return 32'h0010_0000 | (r & 32'h000F_FFFC);
            5: return 32'h1000_0000 | (r & 32'h0FFF_FFFC);
            default: return TB_BASE[k];
        endcase
    endfunction

    task automatic check_err();
        check("err", 64'(err), 64'(m_err));
        check("err_to", 64'(err_to), 64'(m_to));
        check("err_adr", 64'(err_adr), 64'(m_adr));
    endtask

    // Model of what the edge ending this cycle does to the error latch
    task automatic model_edge(input bit evt, input bit to,
                              input logic [31:0] a, input bit clr);
        if (evt && (!m_err || clr)) begin
            m_err = 1'b1;
            m_to  = to;
            m_adr = a;
        end else if (clr) begin
            m_err = 1'b0;
            m_to  = 1'b0;
            m_adr = '0;
        end
    endtask

    task automatic noise();
        for (int j = 0; j < N; j++) begin
            s_rdt[j*32 +: 32] = $urandom;
            s_ack[j] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle_cycles(input int n, input bit clr_force);
        bit clr;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wb_cyc = 1'b0;
            wb_adr = $urandom;
            noise();
            clr = clr_force || ($urandom_range(0, 7) == 0);
            err_clr = clr;
            #1;
            check("idle_cyc", 64'(s_cyc), 64'(0));
            check("idle_ack", 64'(wb_ack), 64'(0));
            check("idle_rdt", 64'(wb_rdt), 64'(0));
            check_err();
            model_edge(1'b0, 1'b0, '0, clr);
        end
        @(negedge clk);
        err_clr = 1'b0;
        s_ack = '0;
    endtask

    // One master transaction; d = slave ack delay (>=TO: never in time)
    task automatic run_txn(input logic [31:0] adr, input logic we,
                           input logic [31:0] dat, input int d,
                           input int abort_at, input bit clr0);
        int k, ack_t, scyc_last, cyc_last, last_t;
        bit tmo;
        logic [N-1:0] oh;
        logic [31:0] exp_rdt;
        bit clr;
        k = ref_target(adr);
        tmo = 1'b0;
        oh = (k >= 0) ? N'(1 << k) : '0;
        if (k < 0 || TB_AUTO[k]) begin
            ack_t = 1; scyc_last = (k < 0) ? 0 : 1;
            cyc_last = 1; last_t = 2;
        end else if (abort_at >= 0) begin
            ack_t = -1; scyc_last = abort_at;
            cyc_last = abort_at; last_t = abort_at + 2;
        end else if (d <= TO - 1) begin
            ack_t = 1 + d; scyc_last = 1 + d;
            cyc_last = 1 + d; last_t = 2 + d;
        end else begin
            tmo = 1'b1;
            ack_t = TO + 1; scyc_last = TO;
            cyc_last = TO + 1; last_t = TO + 2;
        end
        for (int t = 0; t <= last_t; t++) begin
            @(negedge clk);
            wb_cyc = (t <= cyc_last);
            wb_adr = adr;
            wb_we  = we;
            wb_dat = dat;
            wb_sel = 4'($urandom);
            noise();
            if (k >= 0 && !TB_AUTO[k]) begin
                if (abort_at >= 0)
                    s_ack[k] = (t == abort_at + 1) || (t == abort_at + 2);
                else
                    s_ack[k] = (t == 1 + d) ||
                               (t == 0 && $urandom_range(0, 1) == 1);
            end
            clr = (t == 0) && clr0;
            err_clr = clr;
            #1;
            exp_rdt = '0;
            if (t == ack_t)
                exp_rdt = (k < 0 || tmo) ? DEAD : s_rdt[k*32 +: 32];
            check("s_cyc", 64'(s_cyc),
                  64'((t >= 1 && t <= scyc_last) ? oh : '0));
            check("wb_ack", 64'(wb_ack), 64'(t == ack_t));
            check("wb_rdt", 64'(wb_rdt), 64'(exp_rdt));
            check_err();
            if (t == 0) begin
                check("s_adr", 64'(s_adr), 64'(adr));
                check("s_dat", 64'(s_dat), 64'(dat));
                check("s_we", 64'(s_we), 64'(we));
                check("s_sel", 64'(s_sel), 64'(wb_sel));
            end
            model_edge((t == 0 && k < 0) || (tmo && t == TO),
                       tmo, adr, clr);
        end
        err_clr = 1'b0;
    endtask

    initial begin
        int k, d, ab;
        logic [31:0] a;
        logic [31:0] unm [4];
        unm = '{32'h0300_0000, 32'h0000_8000,
                32'h2000_0000, 32'h0200_0004};

        repeat (2) @(negedge clk);
        #1;
        check("rst_cyc", 64'(s_cyc), 64'(0));
        check("rst_ack", 64'(wb_ack), 64'(0));
        check("rst_rdt", 64'(wb_rdt), 64'(0));
        check_err();
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3, 1'b0);

        run_txn(32'h0000_0010, 1'b0, 32'h0, 3, -1, 1'b0);
        idle_cycles(1, 1'b0);
        run_txn(32'h0200_0000, 1'b1, 32'h1, 0, -1, 1'b0);
        run_txn(32'h0300_0000, 1'b0, 32'h0, 0, -1, 1'b0);
        idle_cycles(1, 1'b1);
        run_txn(32'h0400_0000, 1'b0, 32'h0, 100, -1, 1'b0);
        run_txn(32'h2000_0000, 1'b1, 32'h5, 0, -1, 1'b0);
        run_txn(32'h0000_8000, 1'b0, 32'h0, 0, -1, 1'b1);
        idle_cycles(1, 1'b1);
        run_txn(32'h0010_0040, 1'b0, 32'h0, 100, 2, 1'b0);
        run_txn(32'h0000_0100, 1'b0, 32'h0, 7, -1, 1'b0);

        // async reset in the middle of a BUSY phase
        @(negedge clk);
        wb_cyc = 1'b1;
        wb_adr = 32'h0400_0000;
        s_ack = '0;
        repeat (3) @(negedge clk);
        #1;
        check("busy_cyc", 64'(s_cyc), 64'(6'b00_1000));
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_cyc", 64'(s_cyc), 64'(0));
        check("arst_ack", 64'(wb_ack), 64'(0));
        m_err = 1'b0; m_to = 1'b0; m_adr = '0;
        check_err();
        @(negedge clk);
        wb_cyc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3, 1'b0);
        run_txn(32'h0000_0020, 1'b0, 32'h0, 1, -1, 1'b0);

        for (int i = 0; i < 80; i++) begin
            d = $urandom_range(0, 10);
            ab = -1;
            if ($urandom_range(0, 9) < 2) begin
                a = unm[$urandom_range(0, 3)];
            end else begin
                k = $urandom_range(0, N - 1);
                a = gen_adr(k);
                if (!TB_AUTO[k] && $urandom_range(0, 6) == 0)
                    ab = $urandom_range(0, 6);
            end
            run_txn(a, 1'($urandom), $urandom, d, ab,
                    $urandom_range(0, 5) == 0);
            idle_cycles($urandom_range(0, 2), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
